// File: rtl/rgb_marker_overlay.sv
// Camera-path overlay: draws calibration markers and blanks pixels outside
// a crop window, with frame-aligned configuration commit.
module rgb_marker_overlay #(
  parameter int CW         = 8,
  parameter int AW         = 13,
  parameter int NMARK      = 4,
  parameter int MSIZE      = 5,
  parameter int BLINK_LOG2 = 5
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iValid,
  input  logic          iFrameStart,
  input  logic [CW-1:0] iR,
  input  logic [CW-1:0] iG,
  input  logic [CW-1:0] iB,
  input  logic [AW-1:0] iRow,
  input  logic [AW-1:0] iCol,
  input  logic [1:0]    iMode,
  input  logic          iCfgWr,
  input  logic [3:0]    iCfgAddr,
  input  logic [AW-1:0] iCfgData,
  output logic          oValid,
  output logic [CW-1:0] oR,
  output logic [CW-1:0] oG,
  output logic [CW-1:0] oB,
  output logic [AW-1:0] oRow,
  output logic [AW-1:0] oCol
);

  function automatic logic [AW-1:0] def_row(int i);
    return (i >= 2) ? AW'(474) : '0;
  endfunction

  function automatic logic [AW-1:0] def_col(int i);
    return (i % 2 == 1) ? AW'(621) : '0;
  endfunction

  logic [AW-1:0]    sh_mr_q [NMARK];
  logic [AW-1:0]    sh_mr_d [NMARK];
  logic [AW-1:0]    sh_mc_q [NMARK];
  logic [AW-1:0]    sh_mc_d [NMARK];
  logic [AW-1:0]    sh_crow_q, sh_crow_d;
  logic [AW-1:0]    sh_ccol_q, sh_ccol_d;
  logic [NMARK-1:0] sh_en_q, sh_en_d;

  logic [AW-1:0]    ac_mr_q [NMARK];
  logic [AW-1:0]    ac_mr_d [NMARK];
  logic [AW-1:0]    ac_mc_q [NMARK];
  logic [AW-1:0]    ac_mc_d [NMARK];
  logic [AW-1:0]    ac_crow_q, ac_crow_d;
  logic [AW-1:0]    ac_ccol_q, ac_ccol_d;
  logic [NMARK-1:0] ac_en_q, ac_en_d;

  logic [BLINK_LOG2:0] blink_q, blink_d;

  always_comb begin
    sh_mr_d   = sh_mr_q;
    sh_mc_d   = sh_mc_q;
    sh_crow_d = sh_crow_q;
    sh_ccol_d = sh_ccol_q;
    sh_en_d   = sh_en_q;
    if (iCfgWr) begin
      for (int i = 0; i < NMARK; i++) begin
        if (iCfgAddr == 4'(2*i))   sh_mr_d[i] = iCfgData;
        if (iCfgAddr == 4'(2*i+1)) sh_mc_d[i] = iCfgData;
      end
      if (iCfgAddr == 4'd8)  sh_crow_d = iCfgData;
      if (iCfgAddr == 4'd9)  sh_ccol_d = iCfgData;
      if (iCfgAddr == 4'd10) sh_en_d   = iCfgData[NMARK-1:0];
    end
  end

  // Commit takes the shadow as it stood before this cycle's write.
  always_comb begin
    ac_mr_d   = ac_mr_q;
    ac_mc_d   = ac_mc_q;
    ac_crow_d = ac_crow_q;
    ac_ccol_d = ac_ccol_q;
    ac_en_d   = ac_en_q;
    blink_d   = blink_q;
    if (iFrameStart) begin
      ac_mr_d   = sh_mr_q;
      ac_mc_d   = sh_mc_q;
      ac_crow_d = sh_crow_q;
      ac_ccol_d = sh_ccol_q;
      ac_en_d   = sh_en_q;
      blink_d   = blink_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < NMARK; i++) begin
        sh_mr_q[i] <= def_row(i);
        sh_mc_q[i] <= def_col(i);
        ac_mr_q[i] <= def_row(i);
        ac_mc_q[i] <= def_col(i);
      end
      sh_crow_q <= AW'(478);
      sh_ccol_q <= AW'(625);
      sh_en_q   <= '1;
      ac_crow_q <= AW'(478);
      ac_ccol_q <= AW'(625);
      ac_en_q   <= '1;
      blink_q   <= '0;
    end else begin
      sh_mr_q   <= sh_mr_d;
      sh_mc_q   <= sh_mc_d;
      sh_crow_q <= sh_crow_d;
      sh_ccol_q <= sh_ccol_d;
      sh_en_q   <= sh_en_d;
      ac_mr_q   <= ac_mr_d;
      ac_mc_q   <= ac_mc_d;
      ac_crow_q <= ac_crow_d;
      ac_ccol_q <= ac_ccol_d;
      ac_en_q   <= ac_en_d;
      blink_q   <= blink_d;
    end
  end

  logic [NMARK-1:0] s1_hit_q, s1_hit_d;
  logic             s1_crop_q, s1_crop_d;
  logic             s1_blink_q, s1_blink_d;
  logic             s1_v_q;
  logic [1:0]       s1_mode_q;
  logic [CW-1:0]    s1_r_q, s1_g_q, s1_b_q;
  logic [AW-1:0]    s1_row_q, s1_col_q;

  // Upper bounds are formed one bit wider so markers at the edge never wrap.
  always_comb begin
    for (int i = 0; i < NMARK; i++) begin
      s1_hit_d[i] = ac_en_q[i]
        && ({1'b0, iRow} >= {1'b0, ac_mr_q[i]})
        && ({1'b0, iRow} < ({1'b0, ac_mr_q[i]} + (AW+1)'(MSIZE)))
        && ({1'b0, iCol} >= {1'b0, ac_mc_q[i]})
        && ({1'b0, iCol} < ({1'b0, ac_mc_q[i]} + (AW+1)'(MSIZE)));
    end
    s1_crop_d  = (iRow < ac_crow_q) && (iCol < ac_ccol_q);
    s1_blink_d = ~blink_q[BLINK_LOG2];
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_hit_q   <= '0;
      s1_crop_q  <= 1'b0;
      s1_blink_q <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_mode_q  <= 2'd0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
    end else begin
      s1_hit_q   <= s1_hit_d;
      s1_crop_q  <= s1_crop_d;
      s1_blink_q <= s1_blink_d;
      s1_v_q     <= iValid;
      s1_mode_q  <= iMode;
      s1_r_q     <= iR;
      s1_g_q     <= iG;
      s1_b_q     <= iB;
      s1_row_q   <= iRow;
      s1_col_q   <= iCol;
    end
  end

  logic          mark_ok;
  logic          v_q;
  logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [AW-1:0] row_q, col_q;

  always_comb begin
    r_d     = s1_r_q;
    g_d     = s1_g_q;
    b_d     = s1_b_q;
    mark_ok = (|s1_hit_q)
      && ((s1_mode_q == 2'd1) || ((s1_mode_q == 2'd2) && s1_blink_q));
    if ((s1_mode_q != 2'd0) && !s1_crop_q) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
    // Walk from the top so the lowest-index hit wins.
    if (mark_ok) begin
      for (int i = NMARK - 1; i >= 0; i--) begin
        if (s1_hit_q[i]) begin
          r_d = (i == 0 || i == 3) ? '1 : '0;
          g_d = (i == 1 || i == 3) ? '1 : '0;
          b_d = (i == 2 || i == 3) ? '1 : '0;
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      v_q   <= 1'b0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      v_q   <= s1_v_q;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      row_q <= s1_row_q;
      col_q <= s1_col_q;
    end
  end

  assign oValid = v_q;
  assign oR     = r_q;
  assign oG     = g_q;
  assign oB     = b_q;
  assign oRow   = row_q;
  assign oCol   = col_q;

endmodule

// File: tb/tb_rgb_marker_overlay.sv
// Directed bench for rgb_marker_overlay: expected pixels are queued as they
// are driven and compared when oValid presents them.
module tb_rgb_marker_overlay;

  localparam int CW = 8;
  localparam int AW = 13;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
  } exp_t;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iValid = 1'b0;
  logic          iFrameStart = 1'b0;
  logic [CW-1:0] iR = '0, iG = '0, iB = '0;
  logic [AW-1:0] iRow = '0, iCol = '0;
  logic [1:0]    iMode = 2'd1;
  logic          iCfgWr = 1'b0;
  logic [3:0]    iCfgAddr = '0;
  logic [AW-1:0] iCfgData = '0;
  logic          oValid;
  logic [CW-1:0] oR, oG, oB;
  logic [AW-1:0] oRow, oCol;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t got;
  exp_t want;

  rgb_marker_overlay #(
    .CW(CW), .AW(AW), .NMARK(4), .MSIZE(5), .BLINK_LOG2(1)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iValid(iValid),
    .iFrameStart(iFrameStart),
    .iR(iR), .iG(iG), .iB(iB), .iRow(iRow), .iCol(iCol),
    .iMode(iMode), .iCfgWr(iCfgWr), .iCfgAddr(iCfgAddr),
    .iCfgData(iCfgData),
    .oValid(oValid), .oR(oR), .oG(oG), .oB(oB),
    .oRow(oRow), .oCol(oCol)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    got = '{r: oR, g: oG, b: oB, row: oRow, col: oCol};
    if (!iRST_N) begin
      checks++;
      assert ({oValid, got} === '0) else begin
        errors++;
        $error("FAIL reset: got v=%0b %h expected all zero", oValid, got);
      end
    end else if (oValid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL unexpected: got %h expected no output", got);
      end else begin
        want = q.pop_front();
        assert (got === want) else begin
          errors++;
          $error("FAIL pixel(%0d,%0d): got rgb=%h/%h/%h rc=%0d,%0d expected rgb=%h/%h/%h",
                 want.row, want.col, oR, oG, oB, oRow, oCol,
                 want.r, want.g, want.b);
        end
      end
    end
  end

  task automatic px(input int row, input int col, input logic [CW-1:0] r,
                    input logic [CW-1:0] g, input logic [CW-1:0] b,
                    input logic [CW-1:0] er, input logic [CW-1:0] eg,
                    input logic [CW-1:0] eb);
    iRow = AW'(row); iCol = AW'(col);
    iR = r; iG = g; iB = b;
    iValid = 1'b1;
    q.push_back('{r: er, g: eg, b: eb, row: AW'(row), col: AW'(col)});
    @(negedge iCLK);
    iValid = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    iCfgWr = 1'b1; iCfgAddr = 4'(a); iCfgData = AW'(d);
    @(negedge iCLK);
    iCfgWr = 1'b0;
  endtask

  task automatic fs();
    iFrameStart = 1'b1;
    @(negedge iCLK);
    iFrameStart = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge iCLK);
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
      $fatal(1, "output timeout");
    end
    repeat (2) @(negedge iCLK);
  endtask

  task automatic do_reset();
    @(posedge iCLK);
    #1 iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    #1 iRST_N = 1'b1;
    @(negedge iCLK);
  endtask

  initial begin
    repeat (2) @(negedge iCLK);
    #1 iRST_N = 1'b1;
    @(negedge iCLK);

    iMode = 2'd1;
    px(2, 2, 8'h10, 8'h20, 8'h30, 8'hFF, 8'h00, 8'h00);
    px(0, 623, 8'h10, 8'h20, 8'h30, 8'h00, 8'hFF, 8'h00);
    px(476, 2, 8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'hFF);
    px(100, 100, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40);
    px(479, 10, 8'h40, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00);
    drain();

    wr(0, 200);
    wr(1, 300);
    px(202, 302, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33);
    fs();
    px(202, 302, 8'h11, 8'h22, 8'h33, 8'hFF, 8'h00, 8'h00);
    px(2, 2, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33);

    wr(6, 8188);
    wr(7, 8188);
    fs();
    px(8190, 8190, 8'h11, 8'h22, 8'h33, 8'hFF, 8'hFF, 8'hFF);
    px(2, 2, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30);
    drain();

    // Mid-frame reset: active markers fall back to defaults.
    do_reset();
    iMode = 2'd2;
    for (int f = 0; f < 8; f++) begin
      if (f % 4 < 2) px(2, 2, 8'h05, 8'h06, 8'h07, 8'hFF, 8'h00, 8'h00);
      else           px(2, 2, 8'h05, 8'h06, 8'h07, 8'h05, 8'h06, 8'h07);
      fs();
    end
    drain();

    iMode = 2'd0;
    px(479, 700, 8'hAB, 8'hAB, 8'hAB, 8'hAB, 8'hAB, 8'hAB);
    iMode = 2'd3;
    px(2, 2, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30);
    px(479, 700, 8'hAB, 8'hAB, 8'hAB, 8'h00, 8'h00, 8'h00);
    iMode = 2'd1;
    wr(10, 'b1110);
    px(2, 2, 8'h10, 8'h20, 8'h30, 8'hFF, 8'h00, 8'h00);
    fs();
    px(2, 2, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30);
    px(0, 623, 8'h10, 8'h20, 8'h30, 8'h00, 8'hFF, 8'h00);

    // Write coinciding with frame start waits for the following commit.
    iCfgWr = 1'b1; iCfgAddr = 4'd10; iCfgData = AW'('b1111);
    iFrameStart = 1'b1;
    @(negedge iCLK);
    iCfgWr = 1'b0; iFrameStart = 1'b0;
    px(2, 2, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30);
    fs();
    px(2, 2, 8'h10, 8'h20, 8'h30, 8'hFF, 8'h00, 8'h00);
    wr(12, 5);
    px(476, 623, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_marker_overlay.md
Name: rgb_marker_overlay

Overview:
- Pipelined, parametrised camera-path overlay stage between the RGB converter and the VGA output.
- Draws up to NMARK solid calibration markers at programmable positions.
- Blanks pixels outside a programmable crop window.
- Supports bypass, static overlay, blinking overlay and crop-only modes.
- Configuration is written through a simple register port into shadow registers. Shadow values become active only at frame start, so markers never tear mid-frame.

Parameters:
- CW, 8, colour channel width
- AW, 13, row/column coordinate width
- NMARK, 4, number of markers (1..4); colours by index: 0 red, 1 green, 2 blue, 3 white
- MSIZE, 5, marker edge length in pixels
- BLINK_LOG2, 5, blink period is 2^BLINK_LOG2 frames on, then the same number of frames off

Ports:
- iCLK, in, 1, pixel clock
- iRST_N, in, 1, asynchronous active-low reset
- iValid, in, 1, pixel qualifier
- iFrameStart, in, 1, one-cycle pulse before the first pixel of a frame
- iR/iG/iB, in, CW each, raw pixel colour
- iRow/iCol, in, AW each, pixel coordinate
- iMode, in, 2, 0 bypass, 1 overlay+crop, 2 blink overlay+crop, 3 crop only
- iCfgWr, in, 1, configuration write strobe
- iCfgAddr, in, 4, configuration register address
- iCfgData, in, AW, configuration write data
- oValid, out, 1, output pixel qualifier
- oR/oG/oB, out, CW each, processed colour
- oRow/oCol, out, AW each, coordinate delayed to align with the output pixel

Behaviour:
- Reset, asynchronous on iRST_N low:
  - oValid=0; oR/oG/oB=0; oRow/oCol=0.
  - Blink frame counter=0.
  - Shadow and active registers take their defaults:
    - marker row/col: M0 (0,0), M1 (0,621), M2 (474,0), M3 (474,621)
    - crop row limit 478, crop col limit 625
    - enable mask = all NMARK bits set
- Register map. Writes go to shadow registers only, on any cycle that iCfgWr=1:
  - addr 2i = marker i row, addr 2i+1 = marker i col, for i<NMARK
  - addr 8 = crop row limit
  - addr 9 = crop col limit
  - addr 10 = enable mask, using the low NMARK bits
  - Writes to other addresses are ignored.
- Commit: on iFrameStart, active <= shadow in a single cycle.
  - If iCfgWr and iFrameStart occur in the same cycle, the new write lands in shadow and is committed at the next iFrameStart, not this one.
- Blink counter: increments on each iFrameStart and wraps naturally at BLINK_LOG2+1 bits.
  - blink_on = ~counter[BLINK_LOG2].
- Pipeline, fixed 2-cycle latency from input to output for data, valid and coordinates:
  - Stage 1 registers the inputs and computes per-marker hit, crop_in and enable.
  - Stage 2 selects the colour and registers the outputs.
  - No stalls; iValid is simply delayed. When valid=0, colour is still computed but is don't-care.
- Marker hit i: row>=mr_i && row<mr_i+MSIZE && col>=mc_i && col<mc_i+MSIZE.
  - The sums are computed at AW+1 bits, so a marker near the coordinate maximum does not wrap to 0.
- crop_in: row<crop_row && col<crop_col.
- Colour select, in priority order:
  - mode 0: raw pixel (no markers, no crop)
  - mode 1 or 2: if any enabled marker hits (and, for mode 2, blink_on), the lowest-index hit marker's colour at full scale, all-ones/all-zeros per channel; otherwise crop rule
  - mode 3 and crop rule: raw pixel if crop_in, else 0
- Marker pixels take priority over crop, so a marker outside the crop window is still drawn.
- iMode is sampled in stage 1 and may change on any cycle. Pixels already in flight complete with the mode they were sampled with.
- Reset asserted mid-frame: outputs clear immediately. Active registers return to defaults, not shadow values. The first frame after reset uses the defaults.

Test Plan:
- Reset, mode 1, pixel (2,2) raw 0x10/0x20/0x30 valid -> two cycles later oValid=1, oR=0xFF, oG=0, oB=0, oRow=2, oCol=2.
- Mode 1, pixels (0,623), (476,2), (100,100) raw 0x40 gray, (479,10) -> outputs in order: green, blue, 0x40 gray, black.
- Write addr 0=200, addr 1=300 mid-frame; pixel (202,302) before iFrameStart -> raw. After iFrameStart -> red. Old (2,2) -> raw.
- Write addr 6=8188, addr 7=8188 (AW=13), commit, pixel (8190,8190) -> white; pixel (2,2) -> not white (no wrap).
- Mode 2, BLINK_LOG2=1: over eight iFrameStart pulses, pixel (2,2) is red for frames 0-1, raw for 2-3, red for 4-5, raw for 6-7 after reset.
- Mode 0, pixel (479,700) raw 0xAB -> 0xAB out. Mode 3, pixel (2,2) -> raw. Enable mask=0b1110 in mode 1 -> pixel (2,2) raw.
